// File: rtl/multih_max_search.sv
`default_nettype none
// ============================================================================
// Module   : multih_max_search
// Brief    : Multi-beat signed max/argmax search for the multi-h trellis.
//            NUM_IN metrics per beat are reduced by a compare tree, then
//            accumulated across 1..BEATS beats. Reports the winning metric
//            and its global state index.
// Revision : 1.0 - initial release
// ============================================================================
module multih_max_search #(
    parameter int SIZE         = 10,
    parameter int NUM_IN       = 4,
    parameter int BEATS        = 16,
    parameter int IDX_W        = 6,
    parameter int INDEX_OFFSET = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [NUM_IN*SIZE-1:0] data,
    output logic                   out_valid,
    output logic [SIZE-1:0]        max_val,
    output logic [IDX_W-1:0]       max_index,
    output logic                   seq_err
);

    localparam int              c_LW        = $clog2(NUM_IN);
    localparam int              c_BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int              c_NODES     = 2 * NUM_IN;
    localparam logic [c_BW:0]   c_CNT_FULL  = (c_BW + 1)'(BEATS);
    localparam logic [c_BW:0]   c_CNT_ONE   = (c_BW + 1)'(1);
    localparam logic [c_BW-1:0] c_BEAT_LAST = c_BW'(BEATS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_BW:0]          r_cnt;      // beats accepted so far, saturates at BEATS

    logic                   r_s1_valid;
    logic                   r_s1_first;
    logic                   r_s1_last;
    logic signed [SIZE-1:0] r_s1_val;
    logic [c_LW-1:0]        r_s1_lane;
    logic [c_BW-1:0]        r_s1_beat;

    logic signed [SIZE-1:0] r_acc_val;
    logic [c_LW-1:0]        r_acc_lane;
    logic [c_BW-1:0]        r_acc_beat;

    // ------------------------------------------------------------------------
    // Beat reduce tree, heap-ordered: node i combines nodes 2i (lower lanes)
    // and 2i+1 (higher lanes). Leaves sit at NUM_IN..2*NUM_IN-1, root at 1.
    // The right child wins only when strictly greater, so ties keep the
    // lower lane.
    // ------------------------------------------------------------------------
    logic signed [SIZE-1:0] w_node_val [1:c_NODES-1];
    logic [c_LW-1:0]        w_node_idx [1:c_NODES-1];

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_leaf
            assign w_node_val[NUM_IN+g] = $signed(data[g*SIZE +: SIZE]);
            assign w_node_idx[NUM_IN+g] = c_LW'(g);
        end
        for (g = 1; g < NUM_IN; g++) begin : g_node
            logic w_take_right;
            assign w_take_right  = w_node_val[2*g+1] > w_node_val[2*g];
            assign w_node_val[g] = w_take_right ? w_node_val[2*g+1] : w_node_val[2*g];
            assign w_node_idx[g] = w_take_right ? w_node_idx[2*g+1] : w_node_idx[2*g];
        end
    endgenerate

    // Beat acceptance, beat numbering (clamped on overflow) and overflow flag
    logic            w_accept;
    logic            w_ovf;
    logic [c_BW-1:0] w_beat;
    always_comb begin
        w_accept = in_valid && (in_first || (r_state == ST_ACCUM));
        w_ovf    = in_valid && !in_first && !in_last &&
                   (r_state == ST_ACCUM) && (r_cnt == c_CNT_FULL);
        if (in_first) begin
            w_beat = '0;
        end else if (r_cnt >= c_CNT_FULL) begin
            w_beat = c_BEAT_LAST;
        end else begin
            w_beat = r_cnt[c_BW-1:0];
        end
    end

    // Framing FSM: search state, beat counter and framing-error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            seq_err <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            if (in_valid) begin
                if (in_first) begin
                    // A first beat while accumulating abandons the old search
                    seq_err <= (r_state == ST_ACCUM);
                    r_cnt   <= c_CNT_ONE;
                    r_state <= in_last ? ST_IDLE : ST_ACCUM;
                end else if (r_state == ST_IDLE) begin
                    seq_err <= 1'b1;
                end else begin
                    seq_err <= w_ovf;
                    if (r_cnt != c_CNT_FULL) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                    if (in_last) begin
                        r_state <= ST_IDLE;
                    end
                end
            end
        end
    end

    // Stage 1: register the beat winner with its tags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_val   <= '0;
            r_s1_lane  <= '0;
            r_s1_beat  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (in_valid) begin
                r_s1_first <= in_first;
                r_s1_last  <= in_last;
                r_s1_val   <= w_node_val[1];
                r_s1_lane  <= w_node_idx[1];
                r_s1_beat  <= w_beat;
            end
        end
    end

    // Stage 2 candidate: first beat loads, later beats must be strictly greater
    logic                   w_s2_take;
    logic signed [SIZE-1:0] w_new_val;
    logic [c_LW-1:0]        w_new_lane;
    logic [c_BW-1:0]        w_new_beat;
    logic [IDX_W-1:0]       w_new_idx;
    always_comb begin
        w_s2_take  = r_s1_first || (r_s1_val > r_acc_val);
        w_new_val  = w_s2_take ? r_s1_val  : r_acc_val;
        w_new_lane = w_s2_take ? r_s1_lane : r_acc_lane;
        w_new_beat = w_s2_take ? r_s1_beat : r_acc_beat;
        // NUM_IN is a power of two, so beat*NUM_IN + lane is a concatenation
        w_new_idx  = IDX_W'({w_new_beat, w_new_lane}) + IDX_W'(INDEX_OFFSET);
    end

    // Stage 2: accumulate across beats and publish on the last beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_val  <= '0;
            r_acc_lane <= '0;
            r_acc_beat <= '0;
            out_valid  <= 1'b0;
            max_val    <= '0;
            max_index  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (r_s1_valid) begin
                r_acc_val  <= w_new_val;
                r_acc_lane <= w_new_lane;
                r_acc_beat <= w_new_beat;
                if (r_s1_last) begin
                    out_valid <= 1'b1;
                    max_val   <= w_new_val;
                    max_index <= w_new_idx;
                end
            end
        end
    end

endmodule
`default_nettype wire
